// File: rtl/cle_sram_arb.sv
// Round-robin arbiter with bounded lock bursts for the CLE 1024x8 label SRAM.
// Optional stall counters are enabled with `define CLE_ARB_STATS_EN.
module cle_sram_arb #(
  parameter int LOCK_MAX = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic       lock0,
  input  logic       lock1,
  input  logic [9:0] addr0,
  input  logic [9:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic [7:0] rdata,
  output logic [9:0] sram_a,
  output logic [7:0] sram_d,
  output logic       sram_wen,
  input  logic [7:0] sram_q
`ifdef CLE_ARB_STATS_EN
  ,
  output logic [15:0] stall0,
  output logic [15:0] stall1
`endif
);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_t;

  own_t       r_own;
  logic       r_last;
  logic [5:0] r_lock_cnt;
  logic       r_rvalid0;
  logic       r_rvalid1;

  logic w_g0;
  logic w_g1;
  logic w_any;
  logic w_lock;
  logic w_cap;

  // A forced release leaves r_last on the burst owner, so the
  // FREE conflict rule hands the next slot to the other side.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (!reset) begin
      unique case (r_own)
        OWN0: w_g0 = req0;
        OWN1: w_g1 = req1;
        default: begin
          if (req0 && req1) begin
            w_g0 = r_last;
            w_g1 = ~r_last;
          end else begin
            w_g0 = req0;
            w_g1 = req1;
          end
        end
      endcase
    end
  end

  assign w_any  = w_g0 | w_g1;
  assign w_lock = w_g1 ? lock1 : (w_g0 & lock0);
  assign w_cap  = (r_lock_cnt == 6'(LOCK_MAX - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_own      <= FREE;
      r_last     <= 1'b1;
      r_lock_cnt <= 6'd0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
    end else begin
      r_rvalid0 <= w_g0 & ~we0;
      r_rvalid1 <= w_g1 & ~we1;
      if (w_any) r_last <= w_g1;
      if (w_any && w_lock && !w_cap) begin
        r_own      <= w_g1 ? OWN1 : OWN0;
        r_lock_cnt <= r_lock_cnt + 6'd1;
      end else begin
        r_own      <= FREE;
        r_lock_cnt <= 6'd0;
      end
    end
  end

  assign gnt0    = w_g0;
  assign gnt1    = w_g1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = sram_q;

  assign sram_a   = w_g0 ? addr0 : (w_g1 ? addr1 : 10'd0);
  assign sram_d   = w_g0 ? wdata0 : (w_g1 ? wdata1 : 8'd0);
  assign sram_wen = w_g0 ? ~we0 : (w_g1 ? ~we1 : 1'b1);

`ifdef CLE_ARB_STATS_EN
  logic [15:0] r_stall0;
  logic [15:0] r_stall1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall0 <= 16'd0;
      r_stall1 <= 16'd0;
    end else begin
      if (req0 && !w_g0 && r_stall0 != 16'hFFFF)
        r_stall0 <= r_stall0 + 16'd1;
      if (req1 && !w_g1 && r_stall1 != 16'hFFFF)
        r_stall1 <= r_stall1 + 16'd1;
    end
  end

  assign stall0 = r_stall0;
  assign stall1 = r_stall1;
`endif

endmodule
